// File: rtl/program_loader.sv
// program_loader: boot/load engine for Single_Cycle_RISC.
// Consumes a 16-bit command stream (valid/ready), writes instruction/data
// words through the CPU external test ports, then pulses the CPU reset,
// releases it into normal mode and waits for done under a watchdog.
module program_loader #(
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 65535
) (
  input  logic        i_clk,
  input  logic        i_clr,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [15:0] i_in_data,
  output logic        o_test_normal,
  output logic        o_ext_instr_we,
  output logic [15:0] o_ext_instr_addr,
  output logic [15:0] o_ext_instr_data,
  output logic        o_ext_data_we,
  output logic [15:0] o_ext_data_addr,
  output logic [15:0] o_ext_data_data,
  output logic        o_cpu_clr,
  input  logic        i_cpu_done,
  output logic        o_busy,
  output logic        o_run_done,
  output logic        o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_CNT, S_LOAD, S_CLR, S_RUN
  } state_t;

  localparam logic [15:0] CLR_M1 = 16'(CLR_CYCLES - 1);
  localparam logic [31:0] TO_M1  = 32'(TIMEOUT - 1);
  localparam logic        WDOG_EN = (TIMEOUT != 0);

  state_t      r_state, w_state_nxt;
  logic        r_tgt_data;     // 0 = instruction block, 1 = data block
  logic [15:0] r_addr;
  logic [15:0] r_cnt;
  logic [15:0] r_clr_cnt;
  logic [31:0] r_wdog;

  logic        r_test_normal, r_cpu_clr, r_run_done, r_err;
  logic        r_iwe, r_dwe;
  logic [15:0] r_iaddr, r_idata, r_daddr, r_ddata;

  logic w_accept, w_start_load, w_start_run, w_bad_cmd, w_write;
  logic w_clr_end, w_done_hit, w_wdog_hit, w_wdog_exp;

  // Handshake: words are only taken in the command/load states, never in reset
  always_comb begin
    o_in_ready = !i_clr && (r_state == S_IDLE || r_state == S_GET_ADDR ||
                            r_state == S_GET_CNT || r_state == S_LOAD);
    o_busy     = !i_clr && (r_state != S_IDLE);
    w_accept   = i_in_valid && o_in_ready;
    w_wdog_exp = WDOG_EN && (r_wdog == TO_M1);
  end

  // Next-state decode plus single-cycle event flags for the datapath
  always_comb begin
    w_state_nxt  = r_state;
    w_start_load = 1'b0;
    w_start_run  = 1'b0;
    w_bad_cmd    = 1'b0;
    w_write      = 1'b0;
    w_clr_end    = 1'b0;
    w_done_hit   = 1'b0;
    w_wdog_hit   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          unique case (i_in_data[15:14])
            2'b00, 2'b01: begin
              w_start_load = 1'b1;
              w_state_nxt  = S_GET_ADDR;
            end
            2'b10: begin
              w_start_run = 1'b1;
              w_state_nxt = S_CLR;
            end
            default: w_bad_cmd = 1'b1;
          endcase
        end
      end
      S_GET_ADDR: if (w_accept) w_state_nxt = S_GET_CNT;
      S_GET_CNT: begin
        if (w_accept) w_state_nxt = (i_in_data == 16'd0) ? S_IDLE : S_LOAD;
      end
      S_LOAD: begin
        if (w_accept) begin
          w_write = 1'b1;
          if (r_cnt == 16'd1) w_state_nxt = S_IDLE;
        end
      end
      S_CLR: begin
        if (r_clr_cnt == CLR_M1) begin
          w_clr_end   = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // done has priority over a simultaneous watchdog expiry
        if (i_cpu_done) begin
          w_done_hit  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_wdog_exp) begin
          w_wdog_hit  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_clr) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Block target, running address and remaining-word counter
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_tgt_data <= 1'b0;
      r_addr     <= 16'd0;
      r_cnt      <= 16'd0;
    end else begin
      if (w_start_load) r_tgt_data <= i_in_data[14];
      if (r_state == S_GET_ADDR && w_accept) r_addr <= i_in_data;
      else if (w_write)                      r_addr <= r_addr + 16'd1;
      if (r_state == S_GET_CNT && w_accept)  r_cnt <= i_in_data;
      else if (w_write)                      r_cnt <= r_cnt - 16'd1;
    end
  end

  // Registered memory write ports; strobes are one cycle, addr/data hold
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_iwe   <= 1'b0;
      r_dwe   <= 1'b0;
      r_iaddr <= 16'd0;
      r_idata <= 16'd0;
      r_daddr <= 16'd0;
      r_ddata <= 16'd0;
    end else begin
      r_iwe <= w_write && !r_tgt_data;
      r_dwe <= w_write &&  r_tgt_data;
      if (w_write && !r_tgt_data) begin
        r_iaddr <= r_addr;
        r_idata <= i_in_data;
      end
      if (w_write && r_tgt_data) begin
        r_daddr <= r_addr;
        r_ddata <= i_in_data;
      end
    end
  end

  // CPU mode/reset control, CLR-phase and watchdog counters, sticky status
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_test_normal <= 1'b0;
      r_cpu_clr     <= 1'b0;
      r_clr_cnt     <= 16'd0;
      r_wdog        <= 32'd0;
      r_run_done    <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      if (w_start_load)     r_test_normal <= 1'b1;
      else if (w_start_run) r_test_normal <= 1'b0;

      if (w_start_run)    r_cpu_clr <= 1'b1;
      else if (w_clr_end) r_cpu_clr <= 1'b0;

      if (w_start_run)            r_clr_cnt <= 16'd0;
      else if (r_state == S_CLR)  r_clr_cnt <= r_clr_cnt + 16'd1;

      if (w_clr_end)              r_wdog <= 32'd0;
      else if (r_state == S_RUN)  r_wdog <= r_wdog + 32'd1;

      if (w_start_load || w_start_run) r_run_done <= 1'b0;
      else if (w_done_hit)             r_run_done <= 1'b1;

      if (w_bad_cmd || w_wdog_hit) r_err <= 1'b1;
    end
  end

  assign o_test_normal    = r_test_normal;
  assign o_ext_instr_we   = r_iwe;
  assign o_ext_instr_addr = r_iaddr;
  assign o_ext_instr_data = r_idata;
  assign o_ext_data_we    = r_dwe;
  assign o_ext_data_addr  = r_daddr;
  assign o_ext_data_data  = r_ddata;
  assign o_cpu_clr        = r_cpu_clr;
  assign o_run_done       = r_run_done;
  assign o_err            = r_err;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: inputs driven and outputs sampled on
// the falling edge; a monitor logs every write strobe with its cycle number.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        i_clr, i_in_valid, i_cpu_done;
  logic [15:0] i_in_data;
  logic        o_in_ready, o_test_normal, o_cpu_clr, o_busy, o_run_done, o_err;
  logic        o_ext_instr_we, o_ext_data_we;
  logic [15:0] o_ext_instr_addr, o_ext_instr_data, o_ext_data_addr, o_ext_data_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct { logic [15:0] a; logic [15:0] d; int c; } wr_t;
  wr_t iq[$];
  wr_t dq[$];

  program_loader #(.CLR_CYCLES(2), .TIMEOUT(16)) dut (
    .i_clk(clk), .i_clr(i_clr), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_data(i_in_data), .o_test_normal(o_test_normal),
    .o_ext_instr_we(o_ext_instr_we), .o_ext_instr_addr(o_ext_instr_addr),
    .o_ext_instr_data(o_ext_instr_data), .o_ext_data_we(o_ext_data_we),
    .o_ext_data_addr(o_ext_data_addr), .o_ext_data_data(o_ext_data_data),
    .o_cpu_clr(o_cpu_clr), .i_cpu_done(i_cpu_done), .o_busy(o_busy),
    .o_run_done(o_run_done), .o_err(o_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_ext_instr_we) iq.push_back(wr_t'{o_ext_instr_addr, o_ext_instr_data, cyc});
    if (o_ext_data_we)  dq.push_back(wr_t'{o_ext_data_addr, o_ext_data_data, cyc});
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Called on a falling edge; returns on the falling edge after the transfer
  task automatic put(input logic [15:0] w);
    int n = 0;
    i_in_valid = 1'b1;
    i_in_data  = w;
    while (!o_in_ready && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!o_in_ready) begin
      errors++;
      $display("FAIL put_ready: word %h never accepted, in_ready=%b want 1", w, o_in_ready);
    end
    @(negedge clk);
    i_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    i_clr = 1'b1; i_in_valid = 1'b0; i_cpu_done = 1'b0;
    repeat (2) @(negedge clk);
    i_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    i_clr = 1'b1; i_in_valid = 1'b1; i_in_data = 16'h0000; i_cpu_done = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (o_in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_clr: got %b want 0", o_in_ready); end
    checks++;
    if ({o_test_normal, o_ext_instr_we, o_ext_data_we, o_cpu_clr, o_busy, o_run_done, o_err} !== 7'd0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000000",
        {o_test_normal, o_ext_instr_we, o_ext_data_we, o_cpu_clr, o_busy, o_run_done, o_err});
    end
    checks++;
    if ({o_ext_instr_addr, o_ext_instr_data, o_ext_data_addr, o_ext_data_data} !== 64'd0) begin
      errors++; $display("FAIL reset_bus: got %h want 0", {o_ext_instr_addr, o_ext_instr_data, o_ext_data_addr, o_ext_data_data});
    end
    i_in_valid = 1'b0;
    i_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (o_in_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: ready=%b busy=%b want 1 0", o_in_ready, o_busy);
    end
  endtask

  task automatic test_load_instr_run();
    iq.delete(); dq.delete();
    put(16'h0000); put(16'h0000); put(16'h0002); put(16'hE020); put(16'hE001);
    @(negedge clk);
    checks++;
    if (iq.size() !== 2) begin errors++; $display("FAIL li_count: got %0d want 2", iq.size()); end
    else begin
      checks++;
      if (iq[0].a !== 16'h0000 || iq[0].d !== 16'hE020) begin
        errors++; $display("FAIL li_w0: got %h/%h want 0000/e020", iq[0].a, iq[0].d); end
      checks++;
      if (iq[1].a !== 16'h0001 || iq[1].d !== 16'hE001) begin
        errors++; $display("FAIL li_w1: got %h/%h want 0001/e001", iq[1].a, iq[1].d); end
      checks++;
      if (iq[1].c !== iq[0].c + 1) begin
        errors++; $display("FAIL li_b2b: cycles %0d,%0d want consecutive", iq[0].c, iq[1].c); end
    end
    checks++;
    if (dq.size() !== 0) begin errors++; $display("FAIL li_no_data: got %0d data writes want 0", dq.size()); end
    checks++;
    if (o_test_normal !== 1'b1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL li_idle: test_normal=%b busy=%b want 1 0", o_test_normal, o_busy); end
    put(16'h8000);
    checks++;
    if (o_cpu_clr !== 1'b1 || o_test_normal !== 1'b0 || o_in_ready !== 1'b0) begin
      errors++; $display("FAIL run_clr1: cpu_clr=%b tn=%b ready=%b want 1 0 0", o_cpu_clr, o_test_normal, o_in_ready); end
    @(negedge clk);
    checks++;
    if (o_cpu_clr !== 1'b1) begin errors++; $display("FAIL run_clr2: cpu_clr=%b want 1", o_cpu_clr); end
    @(negedge clk);
    checks++;
    if (o_cpu_clr !== 1'b0 || o_busy !== 1'b1) begin
      errors++; $display("FAIL run_release: cpu_clr=%b busy=%b want 0 1", o_cpu_clr, o_busy); end
    repeat (9) @(negedge clk);
    i_cpu_done = 1'b1;
    @(negedge clk);
    i_cpu_done = 1'b0;
    checks++;
    if (o_run_done !== 1'b1 || o_busy !== 1'b0 || o_err !== 1'b0) begin
      errors++; $display("FAIL run_done: run_done=%b busy=%b err=%b want 1 0 0", o_run_done, o_busy, o_err); end
  endtask

  task automatic test_data_wrap();
    iq.delete(); dq.delete();
    put(16'h4000); put(16'hFFFF); put(16'h0002); put(16'h0047); put(16'h0089);
    @(negedge clk);
    checks++;
    if (dq.size() !== 2) begin errors++; $display("FAIL dw_count: got %0d want 2", dq.size()); end
    else begin
      checks++;
      if (dq[0].a !== 16'hFFFF || dq[0].d !== 16'h0047 || dq[1].a !== 16'h0000 || dq[1].d !== 16'h0089) begin
        errors++; $display("FAIL dw_wrap: got %h/%h %h/%h want ffff/0047 0000/0089",
          dq[0].a, dq[0].d, dq[1].a, dq[1].d); end
    end
    checks++;
    if (iq.size() !== 0) begin errors++; $display("FAIL dw_no_instr: got %0d instr writes want 0", iq.size()); end
    checks++;
    if (o_test_normal !== 1'b1) begin errors++; $display("FAIL dw_tn_hold: got %b want 1", o_test_normal); end
  endtask

  task automatic test_back_pressure();
    iq.delete(); dq.delete();
    put(16'h4000); put(16'hFFFF); put(16'h0002); put(16'h0047);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (o_ext_data_we !== 1'b0 || o_ext_data_addr !== 16'hFFFF || o_ext_data_data !== 16'h0047) begin
        errors++; $display("FAIL bp_hold%0d: we=%b %h/%h want 0 ffff/0047", k, o_ext_data_we, o_ext_data_addr, o_ext_data_data); end
    end
    put(16'h0089);
    @(negedge clk);
    checks++;
    if (dq.size() !== 2) begin errors++; $display("FAIL bp_count: got %0d want 2", dq.size()); end
    else begin
      checks++;
      if (dq[1].a !== 16'h0000 || dq[1].d !== 16'h0089 || dq[1].c !== dq[0].c + 4) begin
        errors++; $display("FAIL bp_second: got %h/%h gap %0d want 0000/0089 gap 4",
          dq[1].a, dq[1].d, dq[1].c - dq[0].c); end
    end
    put(16'h8000);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (o_in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low%0d: got %b want 0", k, o_in_ready); end
      @(negedge clk);
    end
    i_cpu_done = 1'b1;
    @(negedge clk);
    i_cpu_done = 1'b0;
    checks++;
    if (o_run_done !== 1'b1 || o_in_ready !== 1'b1 || o_test_normal !== 1'b0) begin
      errors++; $display("FAIL bp_end: run_done=%b ready=%b tn=%b want 1 1 0", o_run_done, o_in_ready, o_test_normal); end
  endtask

  task automatic test_edge_cmds();
    iq.delete(); dq.delete();
    put(16'h0000); put(16'h1234); put(16'h0000);
    @(negedge clk);
    checks++;
    if (iq.size() + dq.size() !== 0 || o_busy !== 1'b0 || o_in_ready !== 1'b1) begin
      errors++; $display("FAIL cnt0: writes=%0d busy=%b ready=%b want 0 0 1", iq.size() + dq.size(), o_busy, o_in_ready); end
    checks++;
    if (o_run_done !== 1'b0) begin errors++; $display("FAIL cnt0_rd_clear: run_done=%b want 0", o_run_done); end
    put(16'hC000);
    checks++;
    if (o_err !== 1'b1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL rsvd: err=%b busy=%b want 1 0", o_err, o_busy); end
    put(16'h0000); put(16'h0100); put(16'h0001); put(16'hABCD);
    @(negedge clk);
    checks++;
    if (iq.size() !== 1) begin errors++; $display("FAIL rsvd_after_count: got %0d want 1", iq.size()); end
    else begin
      checks++;
      if (iq[0].a !== 16'h0100 || iq[0].d !== 16'hABCD) begin
        errors++; $display("FAIL rsvd_after_write: got %h/%h want 0100/abcd", iq[0].a, iq[0].d); end
    end
    checks++;
    if (o_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", o_err); end
  endtask

  task automatic test_watchdog();
    do_reset();
    put(16'h8000);
    repeat (17) @(negedge clk);
    checks++;
    if (o_err !== 1'b0 || o_busy !== 1'b1) begin
      errors++; $display("FAIL wd_pre: err=%b busy=%b want 0 1", o_err, o_busy); end
    @(negedge clk);
    checks++;
    if (o_err !== 1'b1 || o_busy !== 1'b0 || o_run_done !== 1'b0) begin
      errors++; $display("FAIL wd_expire: err=%b busy=%b run_done=%b want 1 0 0", o_err, o_busy, o_run_done); end
    do_reset();
    put(16'h8000);
    repeat (17) @(negedge clk);
    i_cpu_done = 1'b1;
    @(negedge clk);
    i_cpu_done = 1'b0;
    checks++;
    if (o_run_done !== 1'b1 || o_err !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL wd_tie: run_done=%b err=%b busy=%b want 1 0 0", o_run_done, o_err, o_busy); end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    iq.delete(); dq.delete();
    put(16'h0000); put(16'h0200); put(16'h0004); put(16'h1111);
    i_clr = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_in_ready, o_test_normal, o_ext_instr_we, o_ext_data_we, o_cpu_clr, o_busy, o_run_done, o_err} !== 8'd0) begin
      errors++; $display("FAIL rml_ctrl: got %b want 00000000",
        {o_in_ready, o_test_normal, o_ext_instr_we, o_ext_data_we, o_cpu_clr, o_busy, o_run_done, o_err}); end
    checks++;
    if ({o_ext_instr_addr, o_ext_instr_data, o_ext_data_addr, o_ext_data_data} !== 64'd0) begin
      errors++; $display("FAIL rml_bus: got %h want 0", {o_ext_instr_addr, o_ext_instr_data, o_ext_data_addr, o_ext_data_data}); end
    i_clr = 1'b0;
    @(negedge clk);
    put(16'h4000); put(16'h0300); put(16'h0001); put(16'h2222);
    @(negedge clk);
    checks++;
    if (iq.size() !== 1 || dq.size() !== 1) begin
      errors++; $display("FAIL rml_counts: instr=%0d data=%0d want 1 1", iq.size(), dq.size()); end
    else begin
      checks++;
      if (dq[0].a !== 16'h0300 || dq[0].d !== 16'h2222 || iq[0].a !== 16'h0200 || iq[0].d !== 16'h1111) begin
        errors++; $display("FAIL rml_writes: instr %h/%h data %h/%h want 0200/1111 0300/2222",
          iq[0].a, iq[0].d, dq[0].a, dq[0].d); end
    end
  endtask

  initial begin
    i_clr = 1'b1; i_in_valid = 1'b0; i_in_data = 16'h0000; i_cpu_done = 1'b0;
    test_reset();
    test_load_instr_run();
    test_data_wrap();
    test_back_pressure();
    test_edge_cmds();
    test_watchdog();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Upstream boot/load engine for `Single_Cycle_RISC`. It accepts a 16-bit command stream over a valid/ready handshake and writes instruction and data words into the CPU through the `ext_instr_*` / `ext_data_*` test ports, with `test_normal` held high while loading. It then resets the CPU, releases it into normal mode, and waits for `done`. It replaces hand-driven load sequences, so program images can come from a UART, JTAG or host FIFO.

## Interface
- `CLR_CYCLES`, default 2: number of cycles `cpu_clr` is held high before the CPU is released (≥1).
- `TIMEOUT`, default 65535: maximum number of RUN cycles to wait for `cpu_done`; 0 disables the watchdog.
- `clk` in 1: system clock; all logic on the rising edge.
- `clr` in 1: reset, synchronous, active-high.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader can accept a word; a transfer occurs when `in_valid` and `in_ready` are both high at a rising edge.
- `in_data` in 16: command or payload word.
- `test_normal` out 1: drives CPU `test_normal`; 1 = external-load mode.
- `ext_instr_we` out 1: instruction-memory write strobe.
- `ext_instr_addr` out 16: instruction-memory write address.
- `ext_instr_data` out 16: instruction-memory write data.
- `ext_data_we` out 1: data-memory write strobe.
- `ext_data_addr` out 16: data-memory write address.
- `ext_data_data` out 16: data-memory write data.
- `cpu_clr` out 1: drives CPU `clr`.
- `cpu_done` in 1: CPU `done` (HLT reached).
- `busy` out 1: high in any state other than IDLE.
- `run_done` out 1: sticky; the last RUN ended with `cpu_done`.
- `err` out 1: sticky; a reserved command or a watchdog expiry occurred.

## Operation
- **Command word** `[15:14]`:
  - 00 = load INSTR block.
  - 01 = load DATA block.
  - 10 = RUN.
  - 11 = reserved.
  - `[13:0]` is ignored.
- **Load command sequence:** header, then base address word, then count word, then exactly `count` payload words.
- **States:** IDLE, GET_ADDR, GET_CNT, LOAD, CLR, RUN.
- **IDLE**, on an accepted word:
  - 00 or 01: latch the target, set `test_normal`=1, clear `run_done`, go to GET_ADDR.
  - 10: go to CLR.
  - 11: set `err`, stay in IDLE.
- **GET_ADDR:** the accepted word loads the 16-bit address register; go to GET_CNT.
- **GET_CNT:** the accepted word loads the 16-bit down-counter.
  - Count = 0: go to IDLE with no writes.
  - Otherwise: go to LOAD.
- **LOAD**, on each accepted word:
  - Register the address and data onto the selected port's addr/data outputs and pulse its `we` high for exactly one cycle.
  - Address increments mod 2^16 (0xFFFF wraps to 0x0000).
  - Counter decrements; when it reaches 0, go to IDLE.
- **CLR:**
  - `test_normal`=0, both `we`=0, `cpu_clr`=1 for `CLR_CYCLES` cycles.
  - Then go to RUN with `cpu_clr`=0 and the watchdog counter cleared.
- **RUN:**
  - `cpu_done`=1: set `run_done`, go to IDLE.
  - Watchdog reaches `TIMEOUT` (when nonzero): set `err`, go to IDLE.
  - If `cpu_done` and watchdog expiry occur in the same cycle, `cpu_done` wins: `run_done` is set and `err` is not.
- **`in_ready`:** high in IDLE, GET_ADDR, GET_CNT and LOAD; low in CLR and RUN.
- **`err`:** cleared only by `clr`.
- **`test_normal` after a load block:** stays 1 between load blocks and back in IDLE; only RUN or `clr` drops it.

## Timing
- **Reset values while `clr` is high, and the first cycle after:**
  - State = IDLE.
  - `in_ready` forced 0 during `clr`.
  - `test_normal`, both `we`, `cpu_clr`, `busy`, `run_done`, `err` = 0.
  - All addr/data outputs = 0x0000.
- **Write latency:** a payload word accepted at edge N gives `we`=1 with its addr/data during cycle N..N+1. The memory captures it at edge N+1.
- **Throughput:** one payload word per cycle with continuous `in_valid`; the `we` pulses are then back-to-back.
- **Held strobe:** with `in_valid` low in LOAD, `we` returns to 0 and addr/data hold their last values.
- **Minimum write count:** a header, address and count costs 3 cycles before the first write.
- **RUN accepted at edge N:**
  - `test_normal` falls and `cpu_clr` rises in cycle N+1.
  - `cpu_clr` stays high for `CLR_CYCLES` cycles.
  - `cpu_done` is sampled from the first RUN-state cycle.
- **Reset mid-operation:** abort at once to the reset values. Memory contents already written are kept, and the partial block is not resumed.

## Test plan
- **Load INSTR then RUN:**
  - Stream 0x0000, 0x0000, 0x0002, 0xE020, 0xE001, then 0x8000.
  - Required:
    - `ext_instr_we` pulses at addr 0x0000 with data 0xE020, then at addr 0x0001 with data 0xE001, on consecutive cycles.
    - `cpu_clr` high for 2 cycles, then `test_normal`=0.
    - With `cpu_done` asserted 10 cycles later, `run_done`=1, `busy`=0.
- **DATA block with wrap:**
  - Stream 0x4000, 0xFFFF, 0x0002, 0x0047, 0x0089.
  - Required: `ext_data_we` at 0xFFFF/0x0047 then 0x0000/0x0089; `ext_instr_we` stays 0.
- **Back-pressure and gaps:**
  - Same DATA block with `in_valid` dropped for 3 cycles mid-payload.
  - Required: no extra writes, addresses contiguous, `in_ready` low during CLR/RUN.
- **Edge commands:**
  - Count 0 → no write strobes, loader returns to IDLE.
  - Command 0xC000 → `err`=1, state IDLE, a following valid load still works.
- **Watchdog:**
  - `TIMEOUT`=16, RUN, `cpu_done` never asserted.
  - Required: `err`=1 and IDLE 16 cycles after RUN entry, `run_done`=0.
  - `cpu_done` in the expiry cycle → `run_done`=1, `err`=0.
- **Reset mid-LOAD:**
  - `clr` asserted after 1 of 4 payload words.
  - Required: all outputs at reset values the next cycle; a fresh header is accepted afterwards.
